// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I core: FSM states, opcodes, mux
// select codes and the control word the main FSM produces each cycle.
package riscv_mc_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_WDATA  = 2'b00;
    localparam logic [1:0] SRCB_IMMEXT = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Immediate format is a pure function of the opcode.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus funct fields to the ALU operation code.
module alu_decoder
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALUCTL_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALUCTL_ADD;
            ALUOP_SUB: alu_control_o = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type sets op[5]; for I-type bit 30 is immediate data.
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b010:  alu_control_o = ALUCTL_SLT;
                    3'b110:  alu_control_o = ALUCTL_OR;
                    3'b111:  alu_control_o = ALUCTL_AND;
                    default: alu_control_o = ALUCTL_ADD;
                endcase
            end
            default: alu_control_o = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control unit of the multicycle RV32I core: Moore FSM sequencing the
// shared memory/ALU datapath, with branch-taken and ALU decode as Mealy terms.
module multicycle_control_fsm
    import riscv_mc_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [2:0]         ImmSrc,
    output logic [STATE_W-1:0] State
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   branch_taken;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMMEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMMEXT;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.adr_src    = 1'b1;
                ctrl.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_WDATA;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMMEXT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = SRCA_RD1;
                ctrl.alu_src_b  = SRCB_WDATA;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            // ALU computes OldPC+4 for the link value while PC takes the DECODE target.
            S_JAL: begin
                ctrl.alu_src_a  = SRCA_OLDPC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_LUI: begin
                ctrl.result_src = RES_IMMEXT;
                ctrl.reg_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // bne inverts the sense of Zero; every other funct3 behaves as beq.
    assign branch_taken = ctrl.branch & ((funct3 == 3'b001) ? ~Zero : Zero);

    assign PCWrite   = ~RST & (ctrl.pc_update | branch_taken);
    assign MemWrite  = ~RST & ctrl.mem_write;
    assign IRWrite   = ~RST & ctrl.ir_write;
    assign RegWrite  = ~RST & ctrl.reg_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ResultSrc = ctrl.result_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ImmSrc    = imm_src_of(op);
    assign State     = state_q;

    alu_decoder u_alu_decoder (
        .alu_op_i      (ctrl.alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class
// through its state sequence and checks enables and selects per cycle.
module tb_multicycle_control_fsm;

    logic       CLK;
    logic       RST;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic [3:0] State;

    // {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite}
    logic [8:0] ctl;
    assign ctl = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite};

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [8:0] C_FETCH = {4'd0, 5'b10010};

    multicycle_control_fsm dut (
        .CLK        (CLK),
        .RST        (RST),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .State      (State)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        @(negedge CLK);
        tick();
        tick();
        n_cmp++;
        if (ctl !== {4'd0, 5'b00000}) begin
            n_err++; $display("FAIL reset_hold: ctl=%b want %b", ctl, {4'd0, 5'b00000});
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_FETCH) begin
            n_err++; $display("FAIL reset_fetch: ctl=%b want %b", ctl, C_FETCH);
        end
        n_cmp++;
        if ({ResultSrc, ALUSrcA, ALUSrcB, ALUControl} !== {2'b10, 2'b00, 2'b10, 3'b000}) begin
            n_err++; $display("FAIL fetch_sel: got %b want %b",
                {ResultSrc, ALUSrcA, ALUSrcB, ALUControl}, {2'b10, 2'b00, 2'b10, 3'b000});
        end
    endtask

    task automatic test_lw();
        logic [8:0] exp [6] = '{C_FETCH, {4'd1, 5'b00000}, {4'd2, 5'b00000},
                                {4'd3, 5'b01000}, {4'd4, 5'b00001}, C_FETCH};
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL lw_c%0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({ALUSrcA, ALUSrcB, ALUControl} !== {2'b10, 2'b01, 3'b000}) begin
                    n_err++; $display("FAIL lw_memadr_sel: got %b want %b",
                        {ALUSrcA, ALUSrcB, ALUControl}, {2'b10, 2'b01, 3'b000});
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (ResultSrc !== 2'b01) begin
                    n_err++; $display("FAIL lw_memwb_res: got %b want 01", ResultSrc);
                end
            end
        end
    endtask

    task automatic test_sw();
        logic [8:0] exp [5] = '{C_FETCH, {4'd1, 5'b00000}, {4'd2, 5'b00000},
                                {4'd5, 5'b01100}, C_FETCH};
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL sw_c%0d: ctl=%b want %b", i, ctl, exp[i]);
            end
        end
        n_cmp++;
        if (ImmSrc !== 3'b001) begin
            n_err++; $display("FAIL sw_immsrc: got %b want 001", ImmSrc);
        end
    endtask

    task automatic test_alu_op(input logic [6:0] opc, input logic [2:0] f3,
                               input logic f7, input logic [2:0] exp_ctl,
                               input logic [1:0] exp_srcb);
        logic [3:0] exec_st;
        logic [8:0] exp [5];
        exec_st = (opc == 7'b0110011) ? 4'd6 : 4'd7;
        exp = '{C_FETCH, {4'd1, 5'b00000}, {exec_st, 5'b00000}, {4'd8, 5'b00001}, C_FETCH};
        op = opc; funct3 = f3; funct7b5 = f7; Zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL alu_op%b_f%b_c%0d: ctl=%b want %b", opc, f3, i, ctl, exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({ALUSrcA, ALUSrcB, ALUControl} !== {2'b10, exp_srcb, exp_ctl}) begin
                    n_err++; $display("FAIL alu_exec_op%b_f%b_b%b: got %b want %b", opc, f3, f7,
                        {ALUSrcA, ALUSrcB, ALUControl}, {2'b10, exp_srcb, exp_ctl});
                end
            end
        end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_pcw);
        logic [8:0] exp [4];
        exp = '{C_FETCH, {4'd1, 5'b00000}, {4'd9, exp_pcw, 4'b0000}, C_FETCH};
        op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0; Zero = z;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL br_f%b_z%b_c%0d: ctl=%b want %b", f3, z, i, ctl, exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({ALUControl, ImmSrc, ALUSrcA} !== {3'b001, 3'b010, 2'b10}) begin
                    n_err++; $display("FAIL br_sel: got %b want %b",
                        {ALUControl, ImmSrc, ALUSrcA}, {3'b001, 3'b010, 2'b10});
                end
            end
        end
    endtask

    task automatic test_jal();
        logic [8:0] exp [5] = '{C_FETCH, {4'd1, 5'b00000}, {4'd10, 5'b10000},
                                {4'd8, 5'b00001}, C_FETCH};
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL jal_c%0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({ALUSrcA, ALUSrcB, ImmSrc} !== {2'b01, 2'b10, 3'b011}) begin
                    n_err++; $display("FAIL jal_sel: got %b want %b",
                        {ALUSrcA, ALUSrcB, ImmSrc}, {2'b01, 2'b10, 3'b011});
                end
            end
        end
    endtask

    task automatic test_lui();
        logic [8:0] exp [4] = '{C_FETCH, {4'd1, 5'b00000}, {4'd11, 5'b00001}, C_FETCH};
        op = 7'b0110111; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL lui_c%0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            if (i == 2) begin
                n_cmp++;
                if ({ResultSrc, ImmSrc} !== {2'b11, 3'b100}) begin
                    n_err++; $display("FAIL lui_sel: got %b want %b", {ResultSrc, ImmSrc}, {2'b11, 3'b100});
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        tick(); tick(); tick();
        n_cmp++;
        if (ctl !== {4'd3, 5'b01000}) begin
            n_err++; $display("FAIL rstmid_memread: ctl=%b want %b", ctl, {4'd3, 5'b01000});
        end
        RST = 1'b1;
        tick();
        n_cmp++;
        if (ctl !== {4'd0, 5'b00000}) begin
            n_err++; $display("FAIL rstmid_forced: ctl=%b want %b", ctl, {4'd0, 5'b00000});
        end
        RST = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== C_FETCH) begin
            n_err++; $display("FAIL rstmid_fetch: ctl=%b want %b", ctl, C_FETCH);
        end
        tick();
        n_cmp++;
        if (ctl !== {4'd1, 5'b00000}) begin
            n_err++; $display("FAIL rstmid_decode: ctl=%b want %b", ctl, {4'd1, 5'b00000});
        end
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (ctl !== C_FETCH) begin
            n_err++; $display("FAIL rstmid_finish: ctl=%b want %b", ctl, C_FETCH);
        end
    endtask

    task automatic test_illegal();
        logic [8:0] exp [3] = '{C_FETCH, {4'd1, 5'b00000}, C_FETCH};
        op = 7'b1111111; funct3 = 3'b111; funct7b5 = 1'b1; Zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_cmp++;
            if (ctl !== exp[i]) begin
                n_err++; $display("FAIL illegal_c%0d: ctl=%b want %b", i, ctl, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu_op(7'b0110011, 3'b000, 1'b1, 3'b001, 2'b00);
        test_alu_op(7'b0110011, 3'b000, 1'b0, 3'b000, 2'b00);
        test_alu_op(7'b0110011, 3'b111, 1'b0, 3'b010, 2'b00);
        test_alu_op(7'b0110011, 3'b110, 1'b0, 3'b011, 2'b00);
        test_alu_op(7'b0010011, 3'b000, 1'b1, 3'b000, 2'b01);
        test_alu_op(7'b0010011, 3'b010, 1'b0, 3'b101, 2'b01);
        test_branch(3'b000, 1'b1, 1'b1);
        test_branch(3'b000, 1'b0, 1'b0);
        test_branch(3'b001, 1'b0, 1'b1);
        test_branch(3'b001, 1'b1, 1'b0);
        test_branch(3'b100, 1'b1, 1'b1);
        test_jal();
        test_lui();
        test_reset_mid();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
